// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier: one multiplier bit per clock,
// one adder, and a shift register formed by {ACC, Q}.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p,
  output logic [1:0]           o_dbg_state
);

  // Handshake: start is sampled only in IDLE; an accepted start raises busy on
  // the next cycle for WIDTH cycles, then done pulses for one cycle with p valid.
  // start seen while busy or done is dropped, never queued.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH:0]       r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_shift;
  logic                 w_last;

  // r_acc[WIDTH] is always zero after a shift, so adding the full register
  // equals adding ACC[WIDTH-1:0]; the adder carry lands in w_sum[WIDTH].
  assign w_addend = r_q[0] ? {1'b0, r_m} : '0;
  assign w_sum    = r_acc + w_addend;
  assign w_shift  = {w_sum, r_q} >> 1;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m   <= '0;
      r_q   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= a;
            r_q   <= b;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          {r_acc, r_q} <= w_shift;
          r_cnt        <= r_cnt + 1'b1;
          if (w_last) r_p <= w_shift[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign p           = r_p;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: directed cases plus a random sweep,
// checked against a plain a*b reference held in an expected queue.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   p;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .p           (p),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one accepted start; returns at the negedge of the first RUN cycle.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic [2*W-1:0] prod;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    prod  = (2*W)'(ta) * (2*W)'(tb_v);
    exp_q.push_back(prod);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Wait for done, checking the remaining busy cycles, latency and product.
  task automatic wait_done(input string tag, input int exp_lat);
    int cyc   = 0;
    int nbusy = 0;
    logic [2*W-1:0] e;
    while (done !== 1'b1 && cyc < 40) begin
      nbusy += int'(busy);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_busy_cycles"}, nbusy, exp_lat);
    if (done === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, "_p"}, 32'(p), 32'(e));
      check({tag, "_busy_at_done"}, 32'(busy), 0);
      @(negedge clk);
      check({tag, "_done_width"}, 32'(done), 0);
    end
  endtask

  initial begin
    int last_done;
    int n_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_p", 32'(p), 0);
    rst = 1'b0;

    start_op(8'd13, 8'd11);
    wait_done("mul_13x11", W);

    start_op(8'd255, 8'd255);
    wait_done("mul_255x255", W);

    start_op(8'd0, 8'd200);
    wait_done("mul_0x200", W);
    start_op(8'd200, 8'd0);
    wait_done("mul_200x0", W);
    start_op(8'd1, 8'd1);
    wait_done("mul_1x1", W);

    // second request during RUN must be dropped
    start_op(8'd6, 8'd7);
    repeat (2) @(negedge clk);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_6x7_drop", W - 3);
    for (int i = 0; i < 5; i++) begin
      check("drop_idle_p", 32'(p), 42);
      check("drop_idle_busy", 32'(busy), 0);
      check("drop_idle_done", 32'(done), 0);
      @(negedge clk);
    end

    // asynchronous abort in the middle of RUN
    start_op(8'd100, 8'd3);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_p", 32'(p), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_op(8'd3, 8'd5);
    wait_done("mul_3x5_after_abort", W);

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clk);
    a = 8'd2;
    b = 8'd3;
    start = 1'b1;
    last_done = -1;
    n_done = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        check("hold_p", 32'(p), 6);
        if (last_done >= 0) check("hold_period", i - last_done, W + 2);
        last_done = i;
      end
    end
    start = 1'b0;
    check("hold_pulses", n_done, 3);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = '1;
      start_op(ra, rb);
      wait_done("rand", W);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
